// File: rtl/ps2_host_tx_if.sv
// Command handshake between a host controller and the PS/2 host-to-device transmitter.
`timescale 1ns/1ps
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       err;

    modport master (output tx_data, tx_start, input busy, done, err);
    modport slave  (input tx_data, tx_start, output busy, done, err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, then shifts one
// command byte out on device clock falling edges and checks the device ACK.
`timescale 1ns/1ps
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 12000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic              CLK100MHZ,
    input  logic              CPU_RESETN,
    input  logic              PS2_CLK,
    input  logic              PS2_DATA,
    ps2_host_tx_if.slave      host,
    output logic              clk_drive_low,
    output logic              data_drive_low
);

    localparam int unsigned IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   clk_prev_q;
    logic [IW-1:0]          inh_q, inh_d;
    logic [TW-1:0]          to_q, to_d;
    logic [3:0]             n_q, n_d;
    logic [7:0]             data_q, data_d;
    logic                   par_q, par_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic clk_s, data_s, clk_fall;
    logic [2:0] bit_idx;

    // Pads idle high, so the synchronizers preset to 1 to avoid a false edge out of reset.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, forming a true shift chain.
            clk_sync_q  <= SYNC_STAGES'({clk_sync_q, PS2_CLK});
            data_sync_q <= SYNC_STAGES'({data_sync_q, PS2_DATA});
            clk_prev_q  <= clk_s;
        end
    end

    assign clk_s    = clk_sync_q[SYNC_STAGES-1];
    assign data_s   = data_sync_q[SYNC_STAGES-1];
    assign clk_fall = clk_prev_q & ~clk_s;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state_q <= IDLE;
            inh_q   <= '0;
            to_q    <= '0;
            n_q     <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            inh_q   <= inh_d;
            to_q    <= to_d;
            n_q     <= n_d;
            data_q  <= data_d;
            par_q   <= par_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first so no path leaves a latch behind.
        state_d = state_q;
        inh_d   = inh_q;
        to_d    = to_q;
        n_d     = n_q;
        data_d  = data_q;
        par_d   = par_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (host.tx_start) begin
                    data_d  = host.tx_data;
                    par_d   = ~^host.tx_data;
                    inh_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                if (inh_q == INH_LAST) begin
                    to_d    = '0;
                    state_d = REQ;
                end else begin
                    inh_d = inh_q + IW'(1);
                end
            end
            REQ: begin
                // The REQ cycle itself counts toward the first-edge timeout.
                n_d     = '0;
                to_d    = to_q + TW'(1);
                state_d = SEND;
            end
            SEND: begin
                if (clk_fall) begin
                    to_d = '0;
                    n_d  = n_q + 4'd1;
                    if (n_q == 4'd10) begin
                        if (!data_s) begin
                            state_d = WAIT_IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (to_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    to_d = to_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clk_drive_low  = 1'b0;
        data_drive_low = 1'b0;
        bit_idx        = 3'(n_q - 4'd1);
        unique case (state_q)
            INHIBIT: clk_drive_low = 1'b1;
            REQ:     data_drive_low = 1'b1;
            SEND: begin
                if (n_q == 4'd0)       data_drive_low = 1'b1;
                else if (n_q <= 4'd8)  data_drive_low = ~data_q[bit_idx];
                else if (n_q == 4'd9)  data_drive_low = ~par_q;
                else                   data_drive_low = 1'b0;
            end
            default: ;
        endcase
    end

    assign host.busy = (state_q != IDLE);
    assign host.done = done_q;
    assign host.err  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a PS/2 device model driving the open-drain bus.
`timescale 1ns/1ps
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 300;
    localparam int HALF = 40;

    typedef struct {
        logic [7:0] data;
        bit         ack;
        bit         inject;
        logic [9:0] exp_bits;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_data_low = 1'b0;
    logic cdl, ddl;
    logic ps2_clk_line, ps2_data_line;

    int n_checks = 0;
    int n_fail = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;

    always #5 clk = ~clk;

    assign ps2_clk_line  = dev_clk & ~cdl;
    assign ps2_data_line = ~dev_data_low & ~ddl;

    ps2_host_tx_if bus();

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) u_dut (
        .CLK100MHZ      (clk),
        .CPU_RESETN     (rst_n),
        .PS2_CLK        (ps2_clk_line),
        .PS2_DATA       (ps2_data_line),
        .host           (bus),
        .clk_drive_low  (cdl),
        .data_drive_low (ddl)
    );

    always @(negedge clk) begin
        if (bus.done) done_cnt <= done_cnt + 1;
        if (bus.err) err_cnt <= err_cnt + 1;
        if (bus.done && bus.err) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues tx_start and follows the inhibit phase up to the REQ cycle.
    task automatic start_tx(input logic [7:0] d, input string tag);
        int cnt;
        cyc(1);
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        cyc(1);
        check({tag, "_latency"}, 32'(cdl), 32'd1);
        bus.tx_start = 1'b0;
        cnt = 0;
        while (cdl && cnt < INH + 10) begin
            cnt++;
            cyc(1);
        end
        check({tag, "_inhibit_len"}, cnt, INH);
        check({tag, "_req_start_low"}, 32'(ddl), 32'd1);
        check({tag, "_req_busy"}, 32'(bus.busy), 32'd1);
    endtask

    task automatic dev_clock(output logic sample);
        dev_clk = 1'b0;
        cyc(HALF);
        sample = ps2_data_line;
        dev_clk = 1'b1;
        cyc(HALF);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int d0, e0, k;
        bit ended;
        logic [9:0] bits;
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(v.data, tag);
        cyc(5);
        check({tag, "_start_bit"}, 32'(ps2_data_line), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            dev_clock(bits[i-1]);
            if (v.inject && i == 5) begin
                bus.tx_data  = 8'hFF;
                bus.tx_start = 1'b1;
                cyc(1);
                bus.tx_start = 1'b0;
                bus.tx_data  = v.data;
            end
        end
        check({tag, "_frame_bits"}, 32'(bits), 32'(v.exp_bits));
        dev_data_low = v.ack;
        cyc(4);
        dev_clk = 1'b0;
        k = 0;
        ended = 1'b0;
        while (k < 4 * HALF) begin
            cyc(1);
            k++;
            if (k == HALF) dev_clk = 1'b1;
            if (k == HALF + 4) dev_data_low = 1'b0;
            if (!bus.busy) begin
                ended = 1'b1;
                break;
            end
        end
        check({tag, "_ended"}, 32'(ended), 32'd1);
        check({tag, "_done_at_end"}, 32'(bus.done), 32'(v.ack));
        check({tag, "_err_at_end"}, 32'(bus.err), 32'(!v.ack));
        check({tag, "_lines_released"}, {30'd0, cdl, ddl}, 32'd0);
        if (v.ack) check({tag, "_bus_idle"}, {30'd0, ps2_clk_line, ps2_data_line}, 32'd3);
        dev_clk = 1'b1;
        dev_data_low = 1'b0;
        cyc(HALF);
        check({tag, "_done_count"}, done_cnt - d0, 32'(v.ack));
        check({tag, "_err_count"}, err_cnt - e0, 32'(!v.ack));
        check({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        vec_t v_f4;
        int d0, e0, k;
        logic s;

        vecs[0] = '{data: 8'hED, ack: 1'b1, inject: 1'b0, exp_bits: 10'h3ED};
        vecs[1] = '{data: 8'h01, ack: 1'b1, inject: 1'b0, exp_bits: 10'h201};
        vecs[2] = '{data: 8'h00, ack: 1'b1, inject: 1'b0, exp_bits: 10'h300};
        vecs[3] = '{data: 8'hED, ack: 1'b0, inject: 1'b0, exp_bits: 10'h3ED};
        vecs[4] = '{data: 8'hED, ack: 1'b1, inject: 1'b1, exp_bits: 10'h3ED};
        v_f4    = '{data: 8'hF4, ack: 1'b1, inject: 1'b0, exp_bits: 10'h2F4};

        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        cyc(3);
        check("reset_outputs", {27'd0, cdl, ddl, bus.busy, bus.done, bus.err}, 32'd0);
        rst_n = 1'b1;
        cyc(2);
        check("idle_after_reset", {27'd0, cdl, ddl, bus.busy, bus.done, bus.err}, 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Device never clocks: error must land exactly TO cycles after REQ.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hA5, "timeout");
        k = 0;
        while (!bus.err && k < TO + 20) begin
            cyc(1);
            k++;
        end
        check("timeout_cycles", k, TO);
        check("timeout_lines", {29'd0, cdl, ddl, bus.busy}, 32'd0);
        cyc(5);
        check("timeout_err_count", err_cnt - e0, 32'd1);
        check("timeout_done_count", done_cnt - d0, 32'd0);

        // Reset in the middle of a frame, during the fifth device clock low phase.
        d0 = done_cnt;
        e0 = err_cnt;
        start_tx(8'hED, "rst");
        cyc(5);
        for (int i = 1; i <= 4; i++) dev_clock(s);
        dev_clk = 1'b0;
        cyc(6);
        check("rst_pre_d4_driven", 32'(ddl), 32'd1);
        rst_n = 1'b0;
        #2;
        check("rst_async_release", {29'd0, cdl, ddl, bus.busy}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        dev_clk = 1'b1;
        cyc(HALF);
        check("rst_no_pulses", (done_cnt - d0) + (err_cnt - e0), 32'd0);

        run_vec(v_f4, "f4_after_rst");

        check("done_err_overlap", both_cnt, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
